// File: rtl/cont_seq.sv
// Sequencer for the W-bit up/down counter: runs up-to, down-to and bounce moves, mirrors the count.
// Optional CONT_PAUSE_EN adds a pause input that stalls an in-progress run.
module cont_seq #(
  parameter int W      = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [W-1:0]      target,
  input  logic [PASS_W-1:0] passes,
`ifdef CONT_PAUSE_EN
  input  logic              pause,
`endif
  output logic              cnt_en,
  output logic              x,
  output logic [W-1:0]      count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, FIN} state_t;

  localparam logic [W-1:0]      MAXC = '1;
  localparam logic [W-1:0]      ONE  = 1;
  localparam logic [PASS_W-1:0] PONE = 1;

  state_t              state_q, state_d;
  logic [W-1:0]        count_d, target_q, target_d;
  logic [1:0]          mode_q, mode_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [W-1:0]        cnt_up, cnt_dn;
  logic                stall;
  logic                bounce;

`ifdef CONT_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign cnt_up = count + ONE;
  assign cnt_dn = count - ONE;
  assign bounce = (mode_q == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count    <= '0;
      mode_q   <= '0;
      target_q <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    mode_d   = mode_q;
    target_d = target_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          target_d = target;
          pass_d   = passes;
          // Zero-length commands go straight to FIN without a step cycle.
          if (mode == 2'b10) begin
            if (passes == '0)        state_d = FIN;
            else if (count != MAXC)  state_d = UP;
            else                     state_d = DOWN;
          end else if (mode == 2'b01) begin
            state_d = (target == count) ? FIN : DOWN;
          end else begin
            state_d = (target == count) ? FIN : UP;
          end
        end
      end
      UP: begin
        if (!stall) begin
          count_d = cnt_up;
          if (bounce) begin
            if (cnt_up == MAXC) state_d = DOWN;
          end else if (cnt_up == target_q) begin
            state_d = FIN;
          end
        end
      end
      DOWN: begin
        if (!stall) begin
          count_d = cnt_dn;
          if (bounce) begin
            // Each arrival at zero completes one pass.
            if (cnt_dn == '0) begin
              pass_d  = pass_q - PONE;
              state_d = (pass_q == PONE) ? FIN : UP;
            end
          end else if (cnt_dn == target_q) begin
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == UP) || (state_q == DOWN);
  assign cnt_en = busy && !stall;
  assign x      = (state_q != DOWN);
  assign done   = (state_q == FIN);

endmodule

// File: tb/tb_cont_seq.sv
// Randomized self-checking bench for cont_seq; expected step sequences come from a move-level model.
module tb_cont_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = '0;
  logic [2:0] target = '0;
  logic [3:0] passes = '0;
`ifdef CONT_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       cnt_en, x, busy, done;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  logic [2:0] mcount = '0;

  always #5 clk = ~clk;

  cont_seq #(.W(3), .PASS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .target(target), .passes(passes),
`ifdef CONT_PAUSE_EN
    .pause(pause),
`endif
    .cnt_en(cnt_en), .x(x), .count(count), .busy(busy), .done(done)
  );

  // Issues one command and checks every step cycle, the done pulse and the following idle cycle.
  task automatic run_cmd(input logic [1:0] m, input logic [2:0] t, input logic [3:0] p,
                         input int glitch, input bit start_in_done, input string name);
    logic [2:0] pre[$];
    bit         dir[$];
    logic [2:0] c;
    int         rem;
    bit         up;
    c = mcount;
    if (m == 2'b10) begin
      rem = p;
      up  = (c != 3'd7);
      while (rem > 0) begin
        if (up) begin
          while (c != 3'd7) begin pre.push_back(c); dir.push_back(1'b1); c = c + 3'd1; end
          up = 1'b0;
        end else begin
          while (c != 3'd0) begin pre.push_back(c); dir.push_back(1'b0); c = c - 3'd1; end
          rem--;
          up = 1'b1;
        end
      end
    end else if (m == 2'b01) begin
      while (c != t) begin pre.push_back(c); dir.push_back(1'b0); c = c - 3'd1; end
    end else begin
      while (c != t) begin pre.push_back(c); dir.push_back(1'b1); c = c + 3'd1; end
    end

    start = 1'b1; mode = m; target = t; passes = p;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); target = 3'($urandom); passes = 4'($urandom);
    for (int i = 0; i < pre.size(); i++) begin
      tests++;
      if ({cnt_en, x, busy, done, count} !== {1'b1, dir[i], 1'b1, 1'b0, pre[i]}) begin
        fails++;
        $display("FAIL %s step %0d: got en=%b x=%b busy=%b done=%b count=%0d, want en=1 x=%b busy=1 done=0 count=%0d",
                 name, i, cnt_en, x, busy, done, count, dir[i], pre[i]);
      end
      if (i == glitch) begin start = 1'b1; mode = 2'b01; target = 3'($urandom); end
      @(posedge clk); #1;
      start = 1'b0;
    end
    tests++;
    if ({cnt_en, busy, done, count} !== {1'b0, 1'b0, 1'b1, c}) begin
      fails++;
      $display("FAIL %s done: got en=%b busy=%b done=%b count=%0d, want en=0 busy=0 done=1 count=%0d",
               name, cnt_en, busy, done, count, c);
    end
    if (start_in_done) begin start = 1'b1; mode = 2'b00; target = c + 3'd3; passes = 4'd1; end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if ({cnt_en, busy, done, count} !== {1'b0, 1'b0, 1'b0, c}) begin
      fails++;
      $display("FAIL %s idle: got en=%b busy=%b done=%b count=%0d, want en=0 busy=0 done=0 count=%0d",
               name, cnt_en, busy, done, count, c);
    end
    mcount = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({cnt_en, x, busy, done, count} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset: got en=%b x=%b busy=%b done=%b count=%0d, want 0 1 0 0 0",
               cnt_en, x, busy, done, count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({cnt_en, busy, done, count} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_release: got en=%b busy=%b done=%b count=%0d, want 0 0 0 0",
               cnt_en, busy, done, count);
    end
    mcount = 3'd0;
  endtask

  task automatic test_directed();
    run_cmd(2'b00, 3'd5, 4'd0, -1, 1'b0, "up_to_5");
    run_cmd(2'b01, 3'd6, 4'd0, -1, 1'b0, "down_wrap_6");
    run_cmd(2'b01, 3'd0, 4'd0, -1, 1'b0, "down_to_0");
    run_cmd(2'b10, 3'd3, 4'd2, -1, 1'b0, "bounce_2");
    run_cmd(2'b11, 3'd2, 4'd0, -1, 1'b0, "mode11_up");
  endtask

  task automatic test_zero_len();
    run_cmd(2'b00, mcount, 4'd0, -1, 1'b0, "zero_up");
    run_cmd(2'b01, mcount, 4'd0, -1, 1'b0, "zero_down");
    run_cmd(2'b10, 3'd4, 4'd0, -1, 1'b0, "zero_bounce");
  endtask

  task automatic test_ignore_start();
    run_cmd(2'b00, mcount + 3'd4, 4'd0, 1, 1'b1, "ignore_start");
    run_cmd(2'b10, 3'd0, 4'd1, 9, 1'b1, "ignore_bounce");
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [2:0] t;
    logic [3:0] p;
    for (int k = 0; k < 30; k++) begin
      m = 2'($urandom_range(0, 3));
      t = 3'($urandom_range(0, 7));
      p = 4'($urandom_range(0, 3));
      run_cmd(m, t, p, $urandom_range(0, 12) - 2, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; mode = 2'b00; target = mcount + 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cnt_en, busy, done, count} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_mid: got en=%b busy=%b done=%b count=%0d, want 0 0 0 0",
               cnt_en, busy, done, count);
    end
    @(posedge clk); #1;
    tests++;
    if ({cnt_en, busy, count} !== {1'b0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_hold: got en=%b busy=%b count=%0d, want 0 0 0", cnt_en, busy, count);
    end
    rst_n = 1'b1;
    mcount = 3'd0;
    @(posedge clk); #1;
  endtask

`ifdef CONT_PAUSE_EN
  task automatic test_pause();
    logic [2:0] c;
    c = mcount;
    start = 1'b1; mode = 2'b00; target = c + 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int j = 0; j < 3; j++) begin
          pause = 1'b1;
          #1;
          tests++;
          if ({cnt_en, busy, count} !== {1'b0, 1'b1, c + 3'd2}) begin
            fails++;
            $display("FAIL pause_hold %0d: got en=%b busy=%b count=%0d, want 0 1 %0d",
                     j, cnt_en, busy, count, c + 3'd2);
          end
          @(posedge clk); #1;
        end
        pause = 1'b0;
      end
      tests++;
      if ({cnt_en, x, busy, count} !== {1'b1, 1'b1, 1'b1, c + 3'(i)}) begin
        fails++;
        $display("FAIL pause_step %0d: got en=%b x=%b busy=%b count=%0d, want 1 1 1 %0d",
                 i, cnt_en, x, busy, count, c + 3'(i));
      end
      @(posedge clk); #1;
    end
    tests++;
    if ({done, busy, count} !== {1'b1, 1'b0, c + 3'd4}) begin
      fails++;
      $display("FAIL pause_done: got done=%b busy=%b count=%0d, want 1 0 %0d", done, busy, count, c + 3'd4);
    end
    @(posedge clk); #1;
    mcount = c + 3'd4;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_ignore_start();
`ifdef CONT_PAUSE_EN
    test_pause();
`endif
    test_random();
    test_reset_mid();
    run_cmd(2'b10, 3'd0, 4'd2, -1, 1'b0, "bounce_after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cont_seq.md
Name: cont_seq

Overview:
Sequencer for the 3-bit up/down counter datapath. It accepts one-shot move commands: count up to a target, count down to a target, or bounce between 0 and max for N passes. It drives the counter's direction (x) and enable, keeps an internal mirror of the count, and pulses done when the move completes. It sits between the top-level command source (switches/buttons FSM) and the counter.

Parameters:
W, 3, counter/target width; max count = 2^W-1
PASS_W, 4, width of bounce pass count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
mode  in  2  00 up-to-target, 01 down-to-target, 10 bounce, 11 reserved (treated as 00)
target  in  W  end value for modes 00/01
passes  in  PASS_W  number of bounce passes for mode 10
cnt_en  out  1  counter step enable
x  out  1  counter direction, 1=up 0=down
count  out  W  mirrored counter value
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE, count=0, cnt_en=0, x=1, busy=0, done=0, latched cmd regs=0; holds while rst_n low, including mid-run.
- States: IDLE, UP, DOWN, DONE. cnt_en, x, busy, done are Moore outputs of state; count is a register.
- IDLE: on start=1 at an edge, latch mode/target/passes. Next state: mode 00/11 -> UP; 01 -> DOWN; 10 -> UP if count<max, else DOWN. Zero-length commands (00/01 with target==count, or 10 with passes==0) -> DONE directly, no cnt_en cycle.
- UP: cnt_en=1, x=1, busy=1; count <= count+1 mod 2^W each edge (7->0 wraps).
- DOWN: cnt_en=1, x=0, busy=1; count <= count-1 mod 2^W (0->7 wraps).
- Modes 00/01: on the edge where the new count equals target -> DONE. Steps = (target-count) mod 2^W for up, (count-target) mod 2^W for down.
- Mode 10: UP reaching max -> DOWN. DOWN reaching 0 decrements pass counter; if remaining==0 -> DONE, else -> UP. A pass is one arrival at 0.
- DONE: one cycle, done=1, busy=0, cnt_en=0; -> IDLE unconditionally.
- start outside IDLE (UP/DOWN/DONE) is ignored, not queued. mode/target/passes changes after latch have no effect.
- busy high from the cycle after start is accepted through the last step cycle.

Optional Feature:
CONT_PAUSE_EN: defined -> extra input pause (1 bit). In UP/DOWN with pause=1: cnt_en=0, count, state and pass counter hold, busy stays 1. pause is ignored in IDLE/DONE. Not defined -> no pause port; a run is never stalled.

Test Plan:
- Reset, count=0, start mode=00 target=5 -> 5 cycles cnt_en=1 x=1, count 1..5, then done=1 one cycle, busy low, IDLE.
- From count=5, start mode=01 target=6 -> 7 steps x=0: 4,3,2,1,0,7,6, then done pulse.
- From count=0, start mode=10 passes=2 -> 28 step cycles; x falls after count hits 7 and rises after hitting 0 (once); ends at count=0 with done.
- start mode=00 target=count, and mode=10 passes=0 -> done next cycle, cnt_en never asserted, count unchanged.
- During an up run, pulse start with mode=01 -> ignored. Assert rst_n=0 mid-run -> count=0, busy=0, cnt_en=0 immediately, before any clock edge.
- With CONT_PAUSE_EN: mode=00 target=4, pause high 3 cycles after 2nd step -> count holds at 2, cnt_en=0, busy=1; resumes and finishes in 4 step cycles total.
